// File: rtl/ascon_pkg.sv
// Shared types, constants and helpers for the Ascon permutation sequencer.
package ascon_pkg;

  // Five 64-bit Ascon state words, x0 in the most significant slot.
  typedef struct packed {
    logic [63:0] x0;
    logic [63:0] x1;
    logic [63:0] x2;
    logic [63:0] x3;
    logic [63:0] x4;
  } ascon_state_t;

  // Round-count selector encoding; 2'b11 is reserved and behaves as P12.
  typedef enum logic [1:0] {
    P12 = 2'b00,
    P8  = 2'b01,
    P6  = 2'b10
  } perm_rounds_e;

  localparam int NUM_ROUNDS = 12;

  // Linear-layer rotate-right amounts per word.
  localparam int ROT_X0_A = 19;
  localparam int ROT_X0_B = 28;
  localparam int ROT_X1_A = 61;
  localparam int ROT_X1_B = 39;
  localparam int ROT_X2_A = 1;
  localparam int ROT_X2_B = 6;
  localparam int ROT_X3_A = 10;
  localparam int ROT_X3_B = 17;
  localparam int ROT_X4_A = 7;
  localparam int ROT_X4_B = 41;

  // Round constant for absolute round index 0..11.
  function automatic logic [63:0] round_const(input logic [3:0] idx);
    return {56'h0, 4'hF - idx, idx};
  endfunction

  // First absolute round index: the last R rounds of p12 are executed.
  function automatic logic [3:0] start_idx(input logic [1:0] sel);
    case (sel)
      P8:      return 4'd4;
      P6:      return 4'd6;
      default: return 4'd0;
    endcase
  endfunction

  // 64-bit rotate right by a constant amount in 1..63.
  function automatic logic [63:0] ror64(input logic [63:0] v, input int unsigned n);
    return (v >> n) | (v << (64 - n));
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon round: constant addition, bitsliced S-box, linear layer.
module ascon_round
  import ascon_pkg::*;
(
  input  ascon_state_t i_state,
  input  logic [3:0]   i_idx,
  output ascon_state_t o_state
);

  logic [63:0] w_a0, w_a1, w_a2, w_a3, w_a4;
  logic [63:0] w_b0, w_b1, w_b2, w_b3, w_b4;
  logic [63:0] w_s0, w_s1, w_s2, w_s3, w_s4;

  // Constant add and S-box input mixing, chi core, S-box output mixing, then diffusion.
  always_comb begin
    w_a0 = i_state.x0 ^ i_state.x4;
    w_a1 = i_state.x1;
    w_a2 = i_state.x2 ^ round_const(i_idx) ^ i_state.x1;
    w_a3 = i_state.x3;
    w_a4 = i_state.x4 ^ i_state.x3;

    w_b0 = w_a0 ^ (~w_a1 & w_a2);
    w_b1 = w_a1 ^ (~w_a2 & w_a3);
    w_b2 = w_a2 ^ (~w_a3 & w_a4);
    w_b3 = w_a3 ^ (~w_a4 & w_a0);
    w_b4 = w_a4 ^ (~w_a0 & w_a1);

    w_s0 = w_b0 ^ w_b4;
    w_s1 = w_b1 ^ w_b0;
    w_s2 = ~w_b2;
    w_s3 = w_b3 ^ w_b2;
    w_s4 = w_b4;

    o_state.x0 = w_s0 ^ ror64(w_s0, ROT_X0_A) ^ ror64(w_s0, ROT_X0_B);
    o_state.x1 = w_s1 ^ ror64(w_s1, ROT_X1_A) ^ ror64(w_s1, ROT_X1_B);
    o_state.x2 = w_s2 ^ ror64(w_s2, ROT_X2_A) ^ ror64(w_s2, ROT_X2_B);
    o_state.x3 = w_s3 ^ ror64(w_s3, ROT_X3_A) ^ ror64(w_s3, ROT_X3_B);
    o_state.x4 = w_s4 ^ ror64(w_s4, ROT_X4_A) ^ ror64(w_s4, ROT_X4_B);
  end

endmodule

// File: rtl/ascon_perm_sequencer.sv
// Iterative Ascon p6/p8/p12 engine: one shared chain of UNROLL rounds per clock.
// Optional abort input enabled by defining ASCON_PERM_ABORT_EN.
module ascon_perm_sequencer
  import ascon_pkg::*;
#(
  parameter int UNROLL      = 1,
  parameter int ROUND_IDX_W = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
`ifdef ASCON_PERM_ABORT_EN
  input  logic        abort_i,
`endif
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [1:0]  rounds_i,
  input  logic [63:0] x0_i,
  input  logic [63:0] x1_i,
  input  logic [63:0] x2_i,
  input  logic [63:0] x3_i,
  input  logic [63:0] x4_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [63:0] x0_o,
  output logic [63:0] x1_o,
  output logic [63:0] x2_o,
  output logic [63:0] x3_o,
  output logic [63:0] x4_o,
  output logic        busy_o
);

  if (UNROLL != 1 && UNROLL != 2) begin : g_bad_unroll
    $error("ascon_perm_sequencer: UNROLL must be 1 or 2");
  end
  if (ROUND_IDX_W < 4) begin : g_bad_idx_w
    $error("ascon_perm_sequencer: ROUND_IDX_W must hold 0..12");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } fsm_e;

  localparam logic [ROUND_IDX_W-1:0] LAST_IDX = ROUND_IDX_W'(NUM_ROUNDS);
  localparam logic [ROUND_IDX_W-1:0] STEP     = ROUND_IDX_W'(UNROLL);

  fsm_e                   r_fsm, w_fsm_nxt;
  ascon_state_t           r_state, w_state_nxt;
  logic [ROUND_IDX_W-1:0] r_idx, w_idx_nxt;
  logic                   w_in_ready, w_out_valid;

  // Round chain: stage g applies absolute round r_idx+g.
  ascon_state_t [UNROLL:0] w_stage;
  assign w_stage[0] = r_state;

  for (genvar g = 0; g < UNROLL; g++) begin : g_round
    logic [ROUND_IDX_W-1:0] w_ridx;
    assign w_ridx = r_idx + ROUND_IDX_W'(g);
    ascon_round u_round (
      .i_state (w_stage[g]),
      .i_idx   (w_ridx[3:0]),
      .o_state (w_stage[g+1])
    );
  end

  // Next-state, datapath load/advance and handshake outputs.
  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_fsm)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid_i) begin
          w_state_nxt = '{x0: x0_i, x1: x1_i, x2: x2_i, x3: x3_i, x4: x4_i};
          w_idx_nxt   = ROUND_IDX_W'(start_idx(rounds_i));
          w_fsm_nxt   = S_RUN;
        end
      end
      S_RUN: begin
        w_state_nxt = w_stage[UNROLL];
        w_idx_nxt   = r_idx + STEP;
        if (r_idx + STEP == LAST_IDX) w_fsm_nxt = S_DONE;
      end
      S_DONE: begin
        w_out_valid = 1'b1;
        if (out_ready_i) w_fsm_nxt = S_IDLE;
      end
      default: w_fsm_nxt = S_IDLE;
    endcase
`ifdef ASCON_PERM_ABORT_EN
    // Abort wins over completion and wipes the job so no stale result leaks.
    if (abort_i && r_fsm != S_IDLE) begin
      w_fsm_nxt   = S_IDLE;
      w_out_valid = 1'b0;
      w_state_nxt = '0;
      w_idx_nxt   = '0;
    end
`endif
  end

  // State, datapath and round index registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_fsm   <= S_IDLE;
      r_state <= '0;
      r_idx   <= '0;
    end else begin
      r_fsm   <= w_fsm_nxt;
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  assign in_ready_o  = w_in_ready;
  assign out_valid_o = w_out_valid;
  assign busy_o      = (r_fsm != S_IDLE);
  assign x0_o        = r_state.x0;
  assign x1_o        = r_state.x1;
  assign x2_o        = r_state.x2;
  assign x3_o        = r_state.x3;
  assign x4_o        = r_state.x4;

endmodule

// File: tb/tb_ascon_perm_sequencer.sv
// Bench for ascon_perm_sequencer: UNROLL=1 and UNROLL=2 instances share stimulus
// and are checked each cycle against a table-driven S-box permutation model.
module tb_ascon_perm_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic abort = 1'b0;
  logic in_valid = 1'b0;
  logic [1:0] rounds = 2'b00;
  logic [319:0] xin = '0;
  logic out_ready = 1'b1;

  logic ir [2];
  logic ov [2];
  logic bz [2];
  logic [63:0] xw [2][5];

  int n_tests = 0;
  int n_fail = 0;

  initial forever #5 clk = ~clk;

  ascon_perm_sequencer #(.UNROLL(1), .ROUND_IDX_W(4)) dut1 (
    .clk_i(clk), .rst_ni(rst_n),
`ifdef ASCON_PERM_ABORT_EN
    .abort_i(abort),
`endif
    .in_valid_i(in_valid), .in_ready_o(ir[0]), .rounds_i(rounds),
    .x0_i(xin[319:256]), .x1_i(xin[255:192]), .x2_i(xin[191:128]),
    .x3_i(xin[127:64]), .x4_i(xin[63:0]),
    .out_valid_o(ov[0]), .out_ready_i(out_ready),
    .x0_o(xw[0][0]), .x1_o(xw[0][1]), .x2_o(xw[0][2]), .x3_o(xw[0][3]), .x4_o(xw[0][4]),
    .busy_o(bz[0])
  );

  ascon_perm_sequencer #(.UNROLL(2), .ROUND_IDX_W(4)) dut2 (
    .clk_i(clk), .rst_ni(rst_n),
`ifdef ASCON_PERM_ABORT_EN
    .abort_i(abort),
`endif
    .in_valid_i(in_valid), .in_ready_o(ir[1]), .rounds_i(rounds),
    .x0_i(xin[319:256]), .x1_i(xin[255:192]), .x2_i(xin[191:128]),
    .x3_i(xin[127:64]), .x4_i(xin[63:0]),
    .out_valid_o(ov[1]), .out_ready_i(out_ready),
    .x0_o(xw[1][0]), .x1_o(xw[1][1]), .x2_o(xw[1][2]), .x3_o(xw[1][3]), .x4_o(xw[1][4]),
    .busy_o(bz[1])
  );

  // ---------------- reference model ----------------
  logic [4:0] sbox_tbl [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  function automatic logic [63:0] rr(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [319:0] model_round(input logic [319:0] s, input int r);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0] c, o;
    int rot [5][2] = '{'{19, 28}, '{61, 39}, '{1, 6}, '{10, 17}, '{7, 41}};
    for (int i = 0; i < 5; i++) x[i] = s[319 - 64*i -: 64];
    x[2] = x[2] ^ 64'((15 - r) * 16 + r);
    for (int b = 0; b < 64; b++) begin
      c = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
      o = sbox_tbl[c];
      for (int i = 0; i < 5; i++) y[i][b] = o[4 - i];
    end
    for (int i = 0; i < 5; i++) x[i] = y[i] ^ rr(y[i], rot[i][0]) ^ rr(y[i], rot[i][1]);
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  function automatic int nrounds(input logic [1:0] sel);
    return (sel == 2'b01) ? 8 : (sel == 2'b10) ? 6 : 12;
  endfunction

  function automatic logic [319:0] model_perm(input logic [319:0] s, input logic [1:0] sel);
    logic [319:0] t = s;
    for (int r = 12 - nrounds(sel); r < 12; r++) t = model_round(t, r);
    return t;
  endfunction

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- per-cycle compare against the model ----------------
  int m_phase [2] = '{0, 0};   // 0 idle, 1 computing, 2 result held
  int m_left [2] = '{0, 0};
  logic [319:0] m_res [2];
  logic [319:0] m_xo [2] = '{'0, '0};
  int lat_arm [2] = '{0, 0};
  int lat [2] = '{0, 0};
  int done_lat [2] = '{0, 0};

  initial begin
    logic [319:0] xo;
    logic exp_ov;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        xo = {xw[d][0], xw[d][1], xw[d][2], xw[d][3], xw[d][4]};
        if (!rst_n) begin
          m_phase[d] = 0; m_xo[d] = '0; lat_arm[d] = 0;
        end
        if (lat_arm[d] != 0) begin
          lat[d]++;
          if (ov[d]) begin done_lat[d] = lat[d]; lat_arm[d] = 0; end
        end
        exp_ov = (m_phase[d] == 2) && !(abort && m_phase[d] != 0);
        chk($sformatf("d%0d.in_ready", d), 320'(ir[d]), 320'(m_phase[d] == 0));
        chk($sformatf("d%0d.out_valid", d), 320'(ov[d]), 320'(exp_ov));
        chk($sformatf("d%0d.busy", d), 320'(bz[d]), 320'(m_phase[d] != 0));
        if (m_phase[d] != 1) chk($sformatf("d%0d.x_o", d), xo, m_xo[d]);
        if (rst_n) begin
          if (abort && m_phase[d] != 0) begin
            m_phase[d] = 0; m_xo[d] = '0; lat_arm[d] = 0;
          end else if (m_phase[d] == 0) begin
            if (in_valid) begin
              m_phase[d] = 1;
              m_left[d] = nrounds(rounds) / (d + 1);
              m_res[d] = model_perm(xin, rounds);
              lat_arm[d] = 1; lat[d] = 0;
            end
          end else if (m_phase[d] == 1) begin
            m_left[d]--;
            if (m_left[d] == 0) begin m_phase[d] = 2; m_xo[d] = m_res[d]; end
          end else if (out_ready) begin
            m_phase[d] = 0;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [319:0] KS = {64'h4523ee200ecf8b77, 64'he54828cae6d1d407,
                                 64'h96771780123039c0, 64'h57fb8c67866bbd13,
                                 64'h372004a82f4c80ff};

  // Presents one job for a single cycle; both instances are idle, so it is accepted.
  task automatic drive_job(input logic [319:0] s, input logic [1:0] sel);
    done_lat[0] = 0; done_lat[1] = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; xin = s; rounds = sel;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Latency counts rising edges from the accept edge through the edge raising out_valid.
  task automatic check_lat(input string name, input int l1, input int l2);
    repeat (22) @(negedge clk);
    chk({name, ".lat_u1"}, 320'(done_lat[0]), 320'(l1));
    chk({name, ".lat_u2"}, 320'(done_lat[1]), 320'(l2));
  endtask

  initial begin
    #1 rst_n = 1'b0;
    // Model pin: round 0 of the all-zero state, worked by hand.
    chk("pin.round0", model_round('0, 0),
        {64'h001E0F00000000F0, 64'h00000001E0000770, 64'h3FFFFFFFFFFFFF74,
         64'h3C780000000000F0, 64'h0000000000000000});
    repeat (3) @(posedge clk);
    #1;
    chk("reset.in_ready", 320'({ir[0], ir[1]}), 320'(2'b11));
    chk("reset.out_valid", 320'({ov[0], ov[1]}), 320'(2'b00));
    chk("reset.busy", 320'({bz[0], bz[1]}), 320'(2'b00));
    chk("reset.x_o", {xw[0][0], xw[0][1], xw[0][2], xw[0][3], xw[0][4]}, 320'h0);
    rst_n = 1'b1;

    drive_job('0, 2'b00); check_lat("zero.p12", 13, 7);
    drive_job(KS, 2'b00); check_lat("ks.p12", 13, 7);
    drive_job(KS, 2'b01); check_lat("ks.p8", 9, 5);
    drive_job(KS, 2'b10); check_lat("ks.p6", 7, 4);
    drive_job('0, 2'b11); check_lat("zero.rsv", 13, 7);

    // Back-pressure: result held 20+ cycles, in_valid pulse ignored.
    out_ready = 1'b0;
    drive_job(KS, 2'b01);
    repeat (12) @(posedge clk);
    #1 in_valid = 1'b1; xin = ~KS; rounds = 2'b10;
    @(posedge clk); #1 in_valid = 1'b0; xin = KS;
    repeat (16) @(posedge clk);
    #1;
    chk("bp.in_ready", 320'({ir[0], ir[1]}), 320'(2'b00));
    chk("bp.out_valid", 320'({ov[0], ov[1]}), 320'(2'b11));
    chk("bp.lat_u1", 320'(done_lat[0]), 320'(9));
    chk("bp.lat_u2", 320'(done_lat[1]), 320'(5));
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp.release_ready", 320'({ir[0], ir[1]}), 320'(2'b11));
    chk("bp.release_busy", 320'({bz[0], bz[1]}), 320'(2'b00));

    // Reset in cycle 5 of a p12 job, then a fresh job.
    drive_job(KS, 2'b00);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst.in_ready", 320'({ir[0], ir[1]}), 320'(2'b11));
    chk("arst.out_valid", 320'({ov[0], ov[1]}), 320'(2'b00));
    chk("arst.busy", 320'({bz[0], bz[1]}), 320'(2'b00));
    chk("arst.x_o", {xw[0][0], xw[0][1], xw[0][2], xw[0][3], xw[0][4]}, 320'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    drive_job(KS, 2'b00); check_lat("post_rst.p12", 13, 7);

`ifdef ASCON_PERM_ABORT_EN
    // Abort in RUN cycle 3: no result, then a p6 job completes normally.
    drive_job(KS, 2'b00);
    repeat (2) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    chk("abort.in_ready", 320'({ir[0], ir[1]}), 320'(2'b11));
    repeat (20) @(posedge clk);
    chk("abort.no_valid_u1", 320'(done_lat[0]), 320'(0));
    chk("abort.no_valid_u2", 320'(done_lat[1]), 320'(0));
    drive_job(KS, 2'b10); check_lat("post_abort.p6", 7, 4);
`endif

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
